mem_arbiter: RTL and testbench

- Shares the single-port word memory between the instruction-fetch port (read-only) and the load/store port (read/write with byte mask).
- Sits between the core's fetch and LSU stages and the memory instance.
- Registers each granted command, issues it to memory for exactly one cycle, then routes the one-cycle-latency read data (or a write completion) back to the granted port.
- Default policy is fixed priority with load/store winning; round-robin is an optional feature.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arb_select.sv | 40 ++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory arbiter.
//   arb_state_e : arbiter FSM states
//   port_id_e   : requester identity, also the bit index into req/gnt vectors
//   mem_cmd_t   : latched command (port, we_re, mask, addr, wdata)
package mem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_e;

  typedef struct packed {
    port_id_e            port_id;
    logic                we_re;
    logic [MASK_W-1:0]   mask;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory-side signals.
//   slave  : arbiter view (requests and mem_data_out in; gnt, rsp, mem_* out)
//   master : core/memory view (the mirror image)
interface mem_arbiter_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Address   = 8
);

  // Fetch port
  logic                 if_req;
  logic [Address-1:0]   if_addr;
  logic                 if_gnt;
  logic                 if_rsp_valid;
  logic [DataWidth-1:0] if_rdata;

  // Load/store port
  logic                 ls_req;
  logic                 ls_we_re;
  logic [mem_arb_pkg::MASK_W-1:0] ls_mask;
  logic [Address-1:0]   ls_addr;
  logic [DataWidth-1:0] ls_wdata;
  logic                 ls_gnt;
  logic                 ls_rsp_valid;
  logic [DataWidth-1:0] ls_rdata;

  // Memory side
  logic                 mem_request;
  logic                 mem_we_re;
  logic [mem_arb_pkg::MASK_W-1:0] mem_mask;
  logic [Address-1:0]   mem_address;
  logic [DataWidth-1:0] mem_data_in;
  logic [DataWidth-1:0] mem_data_out;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rsp_valid, if_rdata,
    input  ls_req, ls_we_re, ls_mask, ls_addr, ls_wdata,
    output ls_gnt, ls_rsp_valid, ls_rdata,
    output mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
    input  mem_data_out
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rsp_valid, if_rdata,
    output ls_req, ls_we_re, ls_mask, ls_addr, ls_wdata,
    input  ls_gnt, ls_rsp_valid, ls_rdata,
    input  mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
    output mem_data_out
  );

endinterface

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational winner pick between fetch and load/store.
//   req_i   : request bits, indexed by port_id_e (bit0 = IF, bit1 = LS)
//   last_i  : port granted most recently (used only with round-robin)
//   gnt_c_o : one-hot grant, same indexing as req_i
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of
// fixed LS-over-IF priority.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  port_id_e          last_i,
  output logic [NPORTS-1:0] gnt_c_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On contention the port not granted last wins; single requests always win.
  always_comb begin
    gnt_c_o = '0;
    if (req_i == 2'b11) begin
      gnt_c_o = (last_i == PORT_LS) ? 2'b01 : 2'b10;
    end else begin
      gnt_c_o = req_i;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  // Fixed priority: load/store always beats fetch.
  always_comb begin
    gnt_c_o = '0;
    if (req_i[PORT_LS]) begin
      gnt_c_o[PORT_LS] = 1'b1;
    end else if (req_i[PORT_IF]) begin
      gnt_c_o[PORT_IF] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port word memory between instruction fetch
// (read-only) and load/store (read/write with byte mask).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave -- fetch port, load/store port, memory port
// Each granted command is latched, issued to memory for exactly one cycle
// (ISSUE), and the response is routed back to the owning port in RESP.
// gnt is combinational in the arbitration cycle; everything else comes from
// registers or the registered memory read data.
// Build option: MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration with a
// 1-bit last-grant pointer; otherwise load/store has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_W,
  parameter int unsigned Address   = ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  arb_state_e        state_q;
  mem_cmd_t          cmd_q;
  mem_cmd_t          cmd_d;
  logic              mem_req_q;
  logic              arb_en;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] gnt;
  logic              gnt_any;
  port_id_e          last_q;

  // Arbitration is only open in IDLE and RESP; requests in ISSUE are ignored.
  assign arb_en  = (state_q != ISSUE);
  assign req     = {bus.ls_req, bus.if_req} & {NPORTS{arb_en}};
  assign gnt_any = |gnt;

  mem_arb_select u_select (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_c_o (gnt)
  );

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // No pointer in the fixed-priority build.
  assign last_q = PORT_IF;
`endif

  // Command about to be latched; fetch commands are reads with an empty mask.
  always_comb begin
    cmd_d = '0;
    if (gnt[PORT_LS]) begin
      cmd_d.port_id = PORT_LS;
      cmd_d.we_re   = bus.ls_we_re;
      cmd_d.mask    = bus.ls_mask;
      cmd_d.addr    = ADDR_W'(bus.ls_addr);
      cmd_d.wdata   = DATA_W'(bus.ls_wdata);
    end else begin
      cmd_d.port_id = PORT_IF;
      cmd_d.addr    = ADDR_W'(bus.if_addr);
    end
  end

  // FSM, command register and memory request strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (gnt_any) begin
            state_q   <= ISSUE;
            cmd_q     <= cmd_d;
            mem_req_q <= 1'b1;
          end else begin
            state_q   <= IDLE;
          end
        end
        ISSUE:   state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-grant pointer; resets to IF so LS wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_IF;
    end else if (gnt_any) begin
      last_q <= gnt[PORT_LS] ? PORT_LS : PORT_IF;
    end
  end
`endif

  // Response routing: only the owning port sees valid, and only reads carry data.
  logic rsp_if;
  logic rsp_ls;
  assign rsp_if = (state_q == RESP) && (cmd_q.port_id == PORT_IF);
  assign rsp_ls = (state_q == RESP) && (cmd_q.port_id == PORT_LS);

  assign bus.if_gnt       = gnt[PORT_IF];
  assign bus.ls_gnt       = gnt[PORT_LS];
  assign bus.if_rsp_valid = rsp_if;
  assign bus.ls_rsp_valid = rsp_ls;
  assign bus.if_rdata     = (rsp_if && !cmd_q.we_re) ? bus.mem_data_out : {DataWidth{1'b0}};
  assign bus.ls_rdata     = (rsp_ls && !cmd_q.we_re) ? bus.mem_data_out : {DataWidth{1'b0}};

  // mem_* other than the strobe simply hold the last latched command.
  assign bus.mem_request  = mem_req_q;
  assign bus.mem_we_re    = cmd_q.we_re;
  assign bus.mem_mask     = cmd_q.mask;
  assign bus.mem_address  = Address'(cmd_q.addr);
  assign bus.mem_data_in  = DataWidth'(cmd_q.wdata);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// behavioural single-port memory (one-cycle read latency, masked writes).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DataWidth(32), .Address(8)) bus ();

  mem_arbiter #(.DataWidth(32), .Address(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model
  logic [31:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h01] = 32'h0101_0101;
    mem[8'h02] = 32'h0202_0202;
    mem[8'h03] = 32'h0303_0303;
    mem[8'h04] = 32'hDEAD_BEEF;
    mem[8'h10] = 32'h1111_1111;
    mem[8'h20] = 32'hFFFF_FFFF;
  end

  always @(posedge clk) begin
    if (bus.mem_request) begin
      if (bus.mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_mask[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
      end else begin
        bus.mem_data_out <= mem[bus.mem_address];
      end
    end
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_if_gnt"},   32'(bus.if_gnt), 32'd0);
    chk({tag, "_ls_gnt"},   32'(bus.ls_gnt), 32'd0);
    chk({tag, "_if_rsp"},   32'(bus.if_rsp_valid), 32'd0);
    chk({tag, "_ls_rsp"},   32'(bus.ls_rsp_valid), 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
    chk({tag, "_mem_req"},  32'(bus.mem_request), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we_re = 1'b0;
    bus.ls_mask  = '0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;

    // ---- Reset state
    #12;
    chk_idle_outputs("rst");
    chk("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_mem_we",   32'(bus.mem_we_re), 32'd0);
    chk("rst_mem_mask", 32'(bus.mem_mask), 32'd0);
    chk("rst_mem_din",  bus.mem_data_in, 32'd0);
    next();
    rst = 1'b0;

    // ---- Test 1: reset in the middle of an LS write issue
    next();
    bus.ls_req = 1'b1; bus.ls_we_re = 1'b1; bus.ls_mask = 4'hF;
    bus.ls_addr = 8'h10; bus.ls_wdata = 32'h5555_5555;
    settle();
    chk("t1_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    next();
    bus.ls_req = 1'b0;
    settle();
    chk("t1_issue_req", 32'(bus.mem_request), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_rst_req", 32'(bus.mem_request), 32'd0);
    chk("t1_rst_addr", 32'(bus.mem_address), 32'd0);
    next();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next();
      settle();
      chk_idle_outputs("t1_after");
    end
    chk("t1_mem_untouched", mem[8'h10], 32'h1111_1111);

    // ---- Test 2: IF read alone
    next();
    bus.if_req = 1'b1; bus.if_addr = 8'h04;
    settle();
    chk("t2_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("t2_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    chk("t2_req_N", 32'(bus.mem_request), 32'd0);
    next();
    bus.if_req = 1'b0;
    settle();
    chk("t2_mem_req", 32'(bus.mem_request), 32'd1);
    chk("t2_mem_addr", 32'(bus.mem_address), 32'h04);
    chk("t2_mem_we", 32'(bus.mem_we_re), 32'd0);
    chk("t2_mem_mask", 32'(bus.mem_mask), 32'd0);
    chk("t2_rsp_N1", 32'(bus.if_rsp_valid), 32'd0);
    next();
    settle();
    chk("t2_if_rsp", 32'(bus.if_rsp_valid), 32'd1);
    chk("t2_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    chk("t2_ls_rsp", 32'(bus.ls_rsp_valid), 32'd0);
    chk("t2_mem_req_off", 32'(bus.mem_request), 32'd0);
    chk("t2_addr_hold", 32'(bus.mem_address), 32'h04);
    next();
    settle();
    chk_idle_outputs("t2_after");

    // ---- Test 3: masked LS write then read-back
    next();
    bus.ls_req = 1'b1; bus.ls_we_re = 1'b1; bus.ls_mask = 4'b0101;
    bus.ls_addr = 8'h20; bus.ls_wdata = 32'hA1B2_C3D4;
    settle();
    chk("t3_w_gnt", 32'(bus.ls_gnt), 32'd1);
    next();
    bus.ls_req = 1'b0;
    settle();
    chk("t3_w_req", 32'(bus.mem_request), 32'd1);
    chk("t3_w_we", 32'(bus.mem_we_re), 32'd1);
    chk("t3_w_mask", 32'(bus.mem_mask), 32'h5);
    chk("t3_w_addr", 32'(bus.mem_address), 32'h20);
    chk("t3_w_din", bus.mem_data_in, 32'hA1B2_C3D4);
    next();
    // Re-request a read in the write's RESP cycle.
    bus.ls_req = 1'b1; bus.ls_we_re = 1'b0; bus.ls_addr = 8'h20;
    settle();
    chk("t3_w_rsp", 32'(bus.ls_rsp_valid), 32'd1);
    chk("t3_w_rdata", bus.ls_rdata, 32'd0);
    chk("t3_w_if_rsp", 32'(bus.if_rsp_valid), 32'd0);
    chk("t3_r_gnt", 32'(bus.ls_gnt), 32'd1);
    chk("t3_mem_word", mem[8'h20], 32'hFFB2_FFD4);
    next();
    bus.ls_req = 1'b0;
    settle();
    chk("t3_r_req", 32'(bus.mem_request), 32'd1);
    chk("t3_r_we", 32'(bus.mem_we_re), 32'd0);
    next();
    settle();
    chk("t3_r_rsp", 32'(bus.ls_rsp_valid), 32'd1);
    chk("t3_r_rdata", bus.ls_rdata, 32'hFFB2_FFD4);

    // ---- Test 6: back-to-back LS reads with re-request in RESP
    next();
    settle();
    chk_idle_outputs("t6_pre");
    bus.ls_req = 1'b1; bus.ls_we_re = 1'b0; bus.ls_addr = 8'h01;
    settle();
    chk("t6_gnt0", 32'(bus.ls_gnt), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      next();  // ISSUE of read i
      if (i < 3) bus.ls_addr = 8'(i + 1);
      else       bus.ls_req  = 1'b0;
      settle();
      chk($sformatf("t6_req%0d", i), 32'(bus.mem_request), 32'd1);
      chk($sformatf("t6_addr%0d", i), 32'(bus.mem_address), 32'(i));
      chk($sformatf("t6_nognt_issue%0d", i), 32'(bus.ls_gnt), 32'd0);
      next();  // RESP of read i
      settle();
      chk($sformatf("t6_rsp%0d", i), 32'(bus.ls_rsp_valid), 32'd1);
      chk($sformatf("t6_rdata%0d", i), bus.ls_rdata, {4{8'(i)}});
      chk($sformatf("t6_memreq_resp%0d", i), 32'(bus.mem_request), 32'd0);
      chk($sformatf("t6_gnt_resp%0d", i), 32'(bus.ls_gnt), (i < 3) ? 32'd1 : 32'd0);
    end
    next();
    settle();
    chk_idle_outputs("t6_after");

    // ---- Contention: fresh reset so the round-robin pointer starts at IF
    rst = 1'b1;
    next();
    rst = 1'b0;
    next();
    bus.ls_req = 1'b1; bus.ls_we_re = 1'b0; bus.ls_addr = 8'h01;
    bus.if_req = 1'b1; bus.if_addr = 8'h04;
    settle();
    chk("tc_first_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    chk("tc_first_if_gnt", 32'(bus.if_gnt), 32'd0);
`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Test 4: fixed priority starves IF until ls_req drops.
    for (int k = 0; k < 3; k++) begin
      next();
      settle();
      chk($sformatf("t4_issue_gnt%0d", k), 32'({bus.ls_gnt, bus.if_gnt}), 32'd0);
      next();
      if (k == 2) bus.ls_req = 1'b0;
      settle();
      chk($sformatf("t4_ls_rsp%0d", k), 32'(bus.ls_rsp_valid), 32'd1);
      chk($sformatf("t4_if_rsp%0d", k), 32'(bus.if_rsp_valid), 32'd0);
      chk($sformatf("t4_ls_rdata%0d", k), bus.ls_rdata, 32'h0101_0101);
      chk($sformatf("t4_ls_gnt%0d", k), 32'(bus.ls_gnt), (k < 2) ? 32'd1 : 32'd0);
      chk($sformatf("t4_if_gnt%0d", k), 32'(bus.if_gnt), (k < 2) ? 32'd0 : 32'd1);
    end
    next();
    bus.if_req = 1'b0;
    next();
    settle();
    chk("t4_if_rsp_final", 32'(bus.if_rsp_valid), 32'd1);
    chk("t4_if_rdata_final", bus.if_rdata, 32'hDEAD_BEEF);
    chk("t4_ls_rsp_final", 32'(bus.ls_rsp_valid), 32'd0);
`else
    // Test 5: round-robin alternates LS, IF, LS, IF.
    for (int k = 0; k < 4; k++) begin
      next();
      if (k == 3) begin
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
      end
      settle();
      chk($sformatf("t5_issue_gnt%0d", k), 32'({bus.ls_gnt, bus.if_gnt}), 32'd0);
      next();
      settle();
      // Response k belongs to LS when k is even.
      chk($sformatf("t5_ls_rsp%0d", k), 32'(bus.ls_rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t5_if_rsp%0d", k), 32'(bus.if_rsp_valid), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t5_ls_rdata%0d", k), bus.ls_rdata, (k % 2 == 0) ? 32'h0101_0101 : 32'd0);
      chk($sformatf("t5_if_rdata%0d", k), bus.if_rdata, (k % 2 == 0) ? 32'd0 : 32'hDEAD_BEEF);
      if (k < 3) begin
        chk($sformatf("t5_if_gnt%0d", k), 32'(bus.if_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("t5_ls_gnt%0d", k), 32'(bus.ls_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
      end
    end
`endif
    next();
    settle();
    chk_idle_outputs("tc_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
